// File: rtl/rvfi_bus_tracker_pkg.sv
// Shared types for the RVFI bus tracker: the queued request entry and the
// byte-mask helper used on both write data and read data.
package rvfi_bus_tracker_pkg;

    localparam int ENTRY_XLEN    = 32;
    localparam int ENTRY_BUSLEN  = 32;
    localparam int ENTRY_MASKLEN = ENTRY_BUSLEN / 8;

    typedef struct packed {
        logic                     insn;
        logic [ENTRY_XLEN-1:0]    addr;
        logic [ENTRY_MASKLEN-1:0] rmask;
        logic [ENTRY_MASKLEN-1:0] wmask;
        logic [ENTRY_BUSLEN-1:0]  wdata;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    // Keeps only the bytes whose mask bit is set; all other bytes read as zero.
    function automatic logic [ENTRY_BUSLEN-1:0] mask_bytes(
        input logic [ENTRY_BUSLEN-1:0]  data,
        input logic [ENTRY_MASKLEN-1:0] mask
    );
        logic [ENTRY_BUSLEN-1:0] result;
        result = '0;
        for (int i = 0; i < ENTRY_MASKLEN; i++) begin
            if (mask[i]) begin
                result[i*8 +: 8] = data[i*8 +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rvfi_bus_tracker_fifo.sv
// Outstanding-request queue: synchronous write, combinational head, and
// wrap-aware pointers whose extra MSB separates full from empty.
module rvfi_bus_tracker_fifo
    import rvfi_bus_tracker_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    output entry_t                   head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH) + 1;

    entry_t        mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          pop_ok;
    logic          push_ok;

    assign empty = (wptr == rptr);
    assign full  = (wptr[PW-1] != rptr[PW-1]) && (wptr[PW-2:0] == rptr[PW-2:0]);
    assign count = wptr - rptr;
    assign head  = mem[rptr[PW-2:0]];

    // A pop frees the head slot in the same edge, so a push into a full
    // queue is legal whenever a pop accompanies it.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (pop_ok) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wptr[PW-2:0]] <= push_data;
        end
    end

endmodule

// File: rtl/rvfi_bus_tracker.sv
// Passive tracker turning an in-order request/response bus into RVFI bus
// trace records. Define RVFI_BUS_TRACKER_BYPASS_EN to pair a same-cycle
// response with a request fired into an empty queue (zero-latency buses).
module rvfi_bus_tracker
    import rvfi_bus_tracker_pkg::*;
#(
    parameter int XLEN   = ENTRY_XLEN,
    parameter int BUSLEN = ENTRY_BUSLEN,
    parameter int DEPTH  = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    // Request handshake: a request is taken only in a cycle where req_valid
    // and req_ready are both high; this block observes and never drives
    // ready. rsp_valid has no ready and always belongs to the oldest request.
    input  logic                    req_valid,
    input  logic                    req_ready,
    input  logic                    req_insn,
    input  logic [XLEN-1:0]         req_addr,
    input  logic [BUSLEN/8-1:0]     req_rmask,
    input  logic [BUSLEN/8-1:0]     req_wmask,
    input  logic [BUSLEN-1:0]       req_wdata,
    input  logic                    rsp_valid,
    input  logic [BUSLEN-1:0]       rsp_rdata,
    output logic                    rvfi_bus_valid,
    output logic                    rvfi_bus_insn,
    output logic                    rvfi_bus_data,
    output logic [XLEN-1:0]         rvfi_bus_addr,
    output logic [BUSLEN/8-1:0]     rvfi_bus_rmask,
    output logic [BUSLEN-1:0]       rvfi_bus_rdata,
    output logic [BUSLEN/8-1:0]     rvfi_bus_wmask,
    output logic [BUSLEN-1:0]       rvfi_bus_wdata,
    output logic [$clog2(DEPTH):0]  outstanding,
    output logic                    err_overflow,
    output logic                    err_orphan
);

    logic        fire;
    logic        bypass;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    entry_t      req_entry;
    entry_t      head;
    entry_t      src;
    logic        rec_take;
    logic        overflow_evt;
    logic        orphan_evt;

    logic        rec_valid;
    entry_t      rec;
    logic [BUSLEN-1:0] rec_rdata;

    assign fire = req_valid && req_ready;

    assign req_entry.insn  = req_insn;
    assign req_entry.addr  = req_addr;
    assign req_entry.rmask = req_rmask;
    assign req_entry.wmask = req_wmask;
    assign req_entry.wdata = mask_bytes(req_wdata, req_wmask);

`ifdef RVFI_BUS_TRACKER_BYPASS_EN
    assign bypass = fire && rsp_valid && fifo_empty;
`else
    assign bypass = 1'b0;
`endif

    assign fifo_pop     = rsp_valid && !fifo_empty;
    assign fifo_push    = fire && !bypass && (!fifo_full || fifo_pop);
    assign overflow_evt = fire && fifo_full && !fifo_pop;
    assign orphan_evt   = rsp_valid && fifo_empty && !bypass;

    // A bypassed request never enters the queue, so its record comes
    // straight from the request inputs instead of the head.
    assign src      = bypass ? req_entry : head;
    assign rec_take = fifo_pop || bypass;

    rvfi_bus_tracker_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (req_entry),
        .pop       (fifo_pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (outstanding)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rec_valid <= 1'b0;
            rec       <= '0;
            rec_rdata <= '0;
        end else begin
            rec_valid <= rec_take;
            if (rec_take) begin
                rec       <= src;
                rec_rdata <= mask_bytes(rsp_rdata, src.rmask);
            end else begin
                rec       <= '0;
                rec_rdata <= '0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_overflow <= 1'b0;
            err_orphan   <= 1'b0;
        end else begin
            if (overflow_evt) begin
                err_overflow <= 1'b1;
            end
            if (orphan_evt) begin
                err_orphan <= 1'b1;
            end
        end
    end

    assign rvfi_bus_valid = rec_valid;
    assign rvfi_bus_insn  = rec.insn;
    assign rvfi_bus_data  = rec_valid && !rec.insn;
    assign rvfi_bus_addr  = rec.addr;
    assign rvfi_bus_rmask = rec.rmask;
    assign rvfi_bus_rdata = rec_rdata;
    assign rvfi_bus_wmask = rec.wmask;
    assign rvfi_bus_wdata = rec.wdata;

endmodule

// File: tb/tb_rvfi_bus_tracker.sv
// Randomised bench for rvfi_bus_tracker with a queue-based reference model
// and a scoreboard monitor that checks every cycle on the falling edge.
module tb_rvfi_bus_tracker;

    localparam int XLEN   = 32;
    localparam int BUSLEN = 32;
    localparam int DEPTH  = 4;
    localparam int MW     = BUSLEN / 8;
    localparam int REC_W  = 2 + XLEN + MW + BUSLEN + MW + BUSLEN;

    // clock/reset block
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic                   req_valid, req_ready, req_insn, rsp_valid;
    logic [XLEN-1:0]        req_addr;
    logic [MW-1:0]          req_rmask, req_wmask;
    logic [BUSLEN-1:0]      req_wdata, rsp_rdata;
    logic                   rvfi_bus_valid, rvfi_bus_insn, rvfi_bus_data;
    logic [XLEN-1:0]        rvfi_bus_addr;
    logic [MW-1:0]          rvfi_bus_rmask, rvfi_bus_wmask;
    logic [BUSLEN-1:0]      rvfi_bus_rdata, rvfi_bus_wdata;
    logic [$clog2(DEPTH):0] outstanding;
    logic                   err_overflow, err_orphan;

    rvfi_bus_tracker #(.XLEN(XLEN), .BUSLEN(BUSLEN), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_insn(req_insn),
        .req_addr(req_addr), .req_rmask(req_rmask), .req_wmask(req_wmask),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rvfi_bus_valid(rvfi_bus_valid), .rvfi_bus_insn(rvfi_bus_insn),
        .rvfi_bus_data(rvfi_bus_data), .rvfi_bus_addr(rvfi_bus_addr),
        .rvfi_bus_rmask(rvfi_bus_rmask), .rvfi_bus_rdata(rvfi_bus_rdata),
        .rvfi_bus_wmask(rvfi_bus_wmask), .rvfi_bus_wdata(rvfi_bus_wdata),
        .outstanding(outstanding), .err_overflow(err_overflow),
        .err_orphan(err_orphan)
    );

    // reference model state
    typedef struct {
        bit                insn;
        logic [XLEN-1:0]   addr;
        logic [MW-1:0]     rmask;
        logic [MW-1:0]     wmask;
        logic [BUSLEN-1:0] wdata;
    } model_req_t;

    model_req_t             model_q[$];
    logic [REC_W-1:0]       exp_q[$];
    bit                     exp_ovf = 1'b0;
    bit                     exp_orph = 1'b0;
    int                     n_tests = 0;
    int                     n_fail = 0;

    function automatic logic [BUSLEN-1:0] keep_bytes(input logic [BUSLEN-1:0] d,
                                                     input logic [MW-1:0] m);
        logic [BUSLEN-1:0] r;
        for (int b = 0; b < MW; b++) begin
            r[b*8 +: 8] = m[b] ? d[b*8 +: 8] : 8'h00;
        end
        return r;
    endfunction

    function automatic logic [REC_W-1:0] make_rec(input model_req_t q,
                                                  input logic [BUSLEN-1:0] rdata);
        return {~q.insn, q.insn, q.addr, q.rmask, keep_bytes(rdata, q.rmask),
                q.wmask, q.wdata};
    endfunction

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [REC_W-1:0] dut_rec();
        return {rvfi_bus_data, rvfi_bus_insn, rvfi_bus_addr, rvfi_bus_rmask,
                rvfi_bus_rdata, rvfi_bus_wmask, rvfi_bus_wdata};
    endfunction

    // driver: inputs change just after the falling edge, and the model applies
    // the effect the next rising edge will have.
    task automatic cycle(input bit v, input bit r, input bit insn,
                         input logic [XLEN-1:0] addr, input logic [MW-1:0] rmask,
                         input logic [MW-1:0] wmask, input logic [BUSLEN-1:0] wdata,
                         input bit rs, input logic [BUSLEN-1:0] rdata);
        model_req_t nr;
        model_req_t hd;
        bit         fire;
        bit         paired;
        @(negedge clock);
        #1;
        req_valid = v; req_ready = r; req_insn = insn; req_addr = addr;
        req_rmask = rmask; req_wmask = wmask; req_wdata = wdata;
        rsp_valid = rs; rsp_rdata = rdata;
        fire = v && r;
        nr.insn = insn; nr.addr = addr; nr.rmask = rmask; nr.wmask = wmask;
        nr.wdata = keep_bytes(wdata, wmask);
        paired = 1'b0;
`ifdef RVFI_BUS_TRACKER_BYPASS_EN
        if (fire && rs && model_q.size() == 0) begin
            exp_q.push_back(make_rec(nr, rdata));
            paired = 1'b1;
        end
`endif
        if (!paired) begin
            if (rs) begin
                if (model_q.size() > 0) begin
                    hd = model_q.pop_front();
                    exp_q.push_back(make_rec(hd, rdata));
                end else begin
                    exp_orph = 1'b1;
                end
            end
            if (fire) begin
                if (model_q.size() < DEPTH) model_q.push_back(nr);
                else exp_ovf = 1'b1;
            end
        end
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic fetch(input logic [XLEN-1:0] addr, input bit rs,
                         input logic [BUSLEN-1:0] rdata);
        cycle(1'b1, 1'b1, 1'b1, addr, 4'hF, 4'h0, '0, rs, rdata);
    endtask

    task automatic respond(input logic [BUSLEN-1:0] rdata);
        cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b1, rdata);
    endtask

    task automatic pulse_reset();
        idle();
        #1 reset = 1'b1;
        model_q.delete();
        exp_q.delete();
        exp_ovf = 1'b0;
        exp_orph = 1'b0;
        #1;
        check("reset_valid", {127'd0, rvfi_bus_valid}, 128'd0);
        check("reset_record", {{(128-REC_W){1'b0}}, dut_rec()}, 128'd0);
        check("reset_outstanding", {125'd0, outstanding}, 128'd0);
        check("reset_errors", {126'd0, err_overflow, err_orphan}, 128'd0);
        #1 reset = 1'b0;
    endtask

    // monitor / scoreboard
    always @(negedge clock) begin
        if (!reset) begin
            if (rvfi_bus_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_record", {{(128-REC_W){1'b0}}, dut_rec()}, 128'd0);
                end else begin
                    check("record", {{(128-REC_W){1'b0}}, dut_rec()},
                          {{(128-REC_W){1'b0}}, exp_q.pop_front()});
                end
            end else begin
                check("idle_zero", {{(128-REC_W){1'b0}}, dut_rec()}, 128'd0);
                if (exp_q.size() != 0) begin
                    check("record_latency", 128'd0, {{(128-REC_W){1'b0}}, exp_q.pop_front()});
                end
            end
            check("outstanding", {125'd0, outstanding}, 128'(model_q.size()));
            check("err_overflow", {127'd0, err_overflow}, {127'd0, exp_ovf});
            check("err_orphan", {127'd0, err_orphan}, {127'd0, exp_orph});
        end
    end

    initial begin
        req_valid = 0; req_ready = 0; req_insn = 0; req_addr = '0;
        req_rmask = '0; req_wmask = '0; req_wdata = '0;
        rsp_valid = 0; rsp_rdata = '0;
        repeat (3) @(negedge clock);
        #2 reset = 1'b0;

        // single read, response three cycles after the request
        cycle(1'b1, 1'b1, 1'b0, 32'h100, 4'hF, 4'h0, '0, 1'b0, '0);
        idle();
        idle();
        respond(32'hDEADBEEF);
        idle();

        // write with partial mask; read data must be fully masked
        cycle(1'b1, 1'b1, 1'b0, 32'h204, 4'h0, 4'b0011, 32'hAABBCCDD, 1'b0, '0);
        respond(32'h12345678);
        idle();

        // six fetches interleaved with responses, then drain
        for (int i = 0; i < 6; i++) begin
            fetch(32'(i * 4), (i >= 2), 32'h1000 + 32'(i));
        end
        while (model_q.size() > 0) respond($urandom);
        idle();

        // full boundary: fill, fire+response at full, then overflow
        for (int i = 0; i < DEPTH; i++) fetch(32'h300 + 32'(i * 4), 1'b0, '0);
        fetch(32'h380, 1'b1, 32'hCAFE0001);
        fetch(32'h3C0, 1'b0, '0);
        respond(32'hCAFE0002);
        idle();
        pulse_reset();

        // same-cycle request and response on an empty queue
        fetch(32'h40, 1'b1, 32'h0BADF00D);
        idle();
        while (model_q.size() > 0) respond($urandom);
        idle();

        // asynchronous reset with two requests outstanding
        pulse_reset();
        fetch(32'h500, 1'b0, '0);
        fetch(32'h504, 1'b0, '0);
        pulse_reset();
        idle();
        idle();

        // randomised traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1, $urandom & 32'hFFFF_FFFC,
                  4'($urandom), 4'($urandom), $urandom,
                  $urandom_range(0, 2) == 0, $urandom);
            if (i == 200) pulse_reset();
        end
        while (model_q.size() > 0) respond($urandom);
        idle();
        idle();
        check("scoreboard_drained", 128'(exp_q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
